lzc_pipe: RTL

- Pipelined, parameterised leading-run counter for the posit decode path, generalising the combinational leading-zero index finder.
- Counts leading zeros, leading ones, or the regime run (bits equal to the MSB) of a WIDTH-bit word.
- Reports the run length, the index of the first terminating bit and the word left-normalised by the run length.
- Two-stage pipeline with valid/ready backpressure and synchronous clear; sits between posit unpack and regime/exponent extraction.

---
 rtl/lzc_pipe_if.sv | 27 ++
 rtl/lzc_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lzc_pipe_if.sv
// rtl/lzc_pipe_if.sv - word/result handshake bundle for the leading-run counter
interface lzc_pipe_if #(
    parameter int WIDTH = 16
) ();
    localparam int CW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic [CW-1:0]    out_index;
    logic [WIDTH-1:0] out_norm;
    logic             out_all_same;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_index, out_norm, out_all_same
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_index, out_norm, out_all_same
    );
endinterface

// File: rtl/lzc_pipe.sv
// rtl/lzc_pipe.sv - two-stage leading zero/one/regime run counter with backpressure
module lzc_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    lzc_pipe_if.slave   bus
);
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam int NSEG = WIDTH / SEG;
    localparam int SW   = $clog2(SEG) + 1;

    // Leading run of tgt inside one segment, scanned from its MSB.
    function automatic logic [SW-1:0] seg_lead(input logic [SEG-1:0] bits, input logic tgt);
        logic [SW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int b = SEG - 1; b >= 0; b--) begin
            if (run && (bits[b] == tgt)) n = n + SW'(1);
            else                         run = 1'b0;
        end
        return n;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q;
    logic                 s1_target_q;
    logic [NSEG-1:0]      s1_all_q;
    logic [NSEG*SW-1:0]   s1_cnt_q;

    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_count_q;
    logic [CW-1:0]        out_index_q;
    logic [WIDTH-1:0]     out_norm_q;
    logic                 out_all_same_q;

    logic adv1, adv2, in_ready_c, accept, load2;
    logic target_c;
    logic [NSEG-1:0]    seg_all_c;
    logic [NSEG*SW-1:0] seg_cnt_c;
    logic [CW-1:0]      cnt_c;
    logic [CW-1:0]      idx_c;
    logic [WIDTH-1:0]   norm_c;
    logic               all_same_c;
    logic               run_c;

    always_comb begin
        adv2        = !out_valid_q || bus.out_ready;
        adv1        = !s1_valid_q || adv2;
        in_ready_c  = adv1 && !clear;
        accept      = bus.in_valid && in_ready_c;
        load2       = adv2 && s1_valid_q;
        s1_valid_d  = clear ? 1'b0 : (accept ? 1'b1 : (adv2 ? 1'b0 : s1_valid_q));
        out_valid_d = clear ? 1'b0 : (adv2 ? s1_valid_q : out_valid_q);
    end

    always_comb begin
        case (bus.in_mode)
            2'd1:    target_c = 1'b1;
            2'd2:    target_c = bus.in_data[WIDTH-1];
            default: target_c = 1'b0;
        endcase
    end

    // Segment 0 is the most significant segment.
    always_comb begin
        seg_all_c = '0;
        seg_cnt_c = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_cnt_c[s*SW +: SW] = seg_lead(bus.in_data[WIDTH-1-s*SEG -: SEG], target_c);
            seg_all_c[s]          = (seg_cnt_c[s*SW +: SW] == SW'(SEG));
        end
    end

    always_comb begin
        cnt_c = '0;
        run_c = 1'b1;
        for (int s = 0; s < NSEG; s++) begin
            if (run_c) begin
                cnt_c = cnt_c + CW'(s1_cnt_q[s*SW +: SW]);
                if (!s1_all_q[s]) run_c = 1'b0;
            end
        end
        all_same_c = (cnt_c == CW'(WIDTH));
        idx_c      = all_same_c ? CW'(WIDTH) : CW'(WIDTH - 1) - cnt_c;
        norm_c     = all_same_c ? '0 : (s1_data_q << cnt_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_target_q    <= 1'b0;
            s1_all_q       <= '0;
            s1_cnt_q       <= '0;
            out_valid_q    <= 1'b0;
            out_count_q    <= '0;
            out_index_q    <= '0;
            out_norm_q     <= '0;
            out_all_same_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                s1_data_q   <= bus.in_data;
                s1_target_q <= target_c;
                s1_all_q    <= seg_all_c;
                s1_cnt_q    <= seg_cnt_c;
            end
            if (load2) begin
                out_count_q    <= cnt_c;
                out_index_q    <= idx_c;
                out_norm_q     <= norm_c;
                out_all_same_q <= all_same_c;
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_norm     = out_norm_q;
    assign bus.out_all_same = out_all_same_q;
endmodule
